snitch_icache_tag_ctrl: RTL and testbench

Sequencer and arbiter for the L0/L1 instruction-cache tag memory, a single-port, 1-cycle-latency SRAM per set. It shares the one tag port between three requesters: the flush/invalidate sweep, the refill tag write and the lookup read. It also performs the tag compare, producing per-set hit and error flags one cycle after a lookup is accepted. It sits between the icache lookup/refill logic and the tag memory wrapper.

---
 rtl/snitch_icache_tag_ctrl.sv | 127 ++++++++++++
 tb/tb_snitch_icache_tag_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_tag_ctrl.sv
// Tag-port sequencer for the instruction cache: arbitrates flush sweep, refill
// writes and lookups onto one single-port tag SRAM per way, and compares tags.
module snitch_icache_tag_ctrl #(
  parameter int SET_COUNT   = 8,
  parameter int LINE_COUNT  = 128,
  parameter int TAG_WIDTH   = 20,
  parameter int COUNT_ALIGN = $clog2(LINE_COUNT),
  parameter int SET_ALIGN   = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_valid_i,
  output logic                              flush_ready_o,
  output logic                              flush_busy_o,
  input  logic                              lookup_valid_i,
  output logic                              lookup_ready_o,
  input  logic [COUNT_ALIGN-1:0]            lookup_addr_i,
  input  logic [TAG_WIDTH-1:0]              lookup_tag_i,
  output logic                              lookup_rvalid_o,
  output logic [SET_COUNT-1:0]              lookup_hit_o,
  output logic                              lookup_err_o,
  input  logic                              write_valid_i,
  output logic                              write_ready_o,
  input  logic [COUNT_ALIGN-1:0]            write_addr_i,
  input  logic [SET_ALIGN-1:0]              write_set_i,
  input  logic [TAG_WIDTH-1:0]              write_tag_i,
  input  logic                              write_err_i,
  output logic [SET_COUNT-1:0]              ram_enable_o,
  output logic                              ram_write_o,
  output logic [COUNT_ALIGN-1:0]            ram_addr_o,
  output logic [SET_COUNT*(TAG_WIDTH+2)-1:0] ram_wtag_o,
  input  logic [SET_COUNT*(TAG_WIDTH+2)-1:0] ram_rtag_i
);

  localparam int EntryWidth = TAG_WIDTH + 2;

  typedef enum logic {
    FLUSH,
    IDLE
  } state_e;

  state_e                 state_q, state_d;
  logic [COUNT_ALIGN-1:0] cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   rvalid_q;
  logic                   lookup_fire;

  assign lookup_fire = (state_q == IDLE) && !flush_valid_i && !write_valid_i && lookup_valid_i;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= FLUSH;
      cnt_q    <= '0;
      tag_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= lookup_fire;
      if (lookup_fire) tag_q <= lookup_tag_i;
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    flush_ready_o  = 1'b0;
    flush_busy_o   = 1'b0;
    write_ready_o  = 1'b0;
    lookup_ready_o = 1'b0;
    ram_enable_o   = '0;
    ram_write_o    = 1'b0;
    ram_addr_o     = '0;
    ram_wtag_o     = '0;

    unique case (state_q)
      FLUSH: begin
        flush_busy_o = 1'b1;
        ram_enable_o = '1;
        ram_write_o  = 1'b1;
        ram_addr_o   = cnt_q;
        if (cnt_q == COUNT_ALIGN'(LINE_COUNT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + COUNT_ALIGN'(1);
        end
      end
      IDLE: begin
        // Readies depend only on higher-priority valids, never on their own.
        flush_ready_o  = 1'b1;
        write_ready_o  = !flush_valid_i;
        lookup_ready_o = !flush_valid_i && !write_valid_i;
        if (flush_valid_i) begin
          state_d = FLUSH;
        end else if (write_valid_i) begin
          ram_enable_o = SET_COUNT'(1) << write_set_i;
          ram_write_o  = 1'b1;
          ram_addr_o   = write_addr_i;
          ram_wtag_o   = {SET_COUNT{write_err_i, 1'b1, write_tag_i}};
        end else if (lookup_valid_i) begin
          ram_enable_o = '1;
          ram_addr_o   = lookup_addr_i;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  // Entry layout per way: {err, valid, tag}; results are gated by rvalid.
  always_comb begin
    lookup_hit_o = '0;
    lookup_err_o = 1'b0;
    for (int i = 0; i < SET_COUNT; i++) begin
      lookup_hit_o[i] = rvalid_q && ram_rtag_i[i*EntryWidth + TAG_WIDTH]
                        && (ram_rtag_i[i*EntryWidth +: TAG_WIDTH] == tag_q);
      lookup_err_o    = lookup_err_o | (lookup_hit_o[i] & ram_rtag_i[i*EntryWidth + TAG_WIDTH + 1]);
    end
  end

  assign lookup_rvalid_o = rvalid_q;

endmodule

// File: tb/tb_snitch_icache_tag_ctrl.sv
// Randomized bench for snitch_icache_tag_ctrl: a tag-store model predicts the
// SRAM port usage and lookup results; a monitor scores responses from a queue.
module tb_snitch_icache_tag_ctrl;

  localparam int SC = 8;
  localparam int LC = 128;
  localparam int TW = 20;
  localparam int AW = $clog2(LC);
  localparam int SA = $clog2(SC);
  localparam int EW = TW + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_ni = 1'b0;
  logic            flush_valid = 1'b0, flush_ready, flush_busy;
  logic            lookup_valid = 1'b0, lookup_ready;
  logic [AW-1:0]   lookup_addr = '0;
  logic [TW-1:0]   lookup_tag = '0;
  logic            lookup_rvalid, lookup_err;
  logic [SC-1:0]   lookup_hit;
  logic            write_valid = 1'b0, write_ready;
  logic [AW-1:0]   write_addr = '0;
  logic [SA-1:0]   write_set = '0;
  logic [TW-1:0]   write_tag = '0;
  logic            write_err = 1'b0;
  logic [SC-1:0]   ram_enable;
  logic            ram_write;
  logic [AW-1:0]   ram_addr;
  logic [SC*EW-1:0] ram_wtag, ram_rtag;

  snitch_icache_tag_ctrl #(.SET_COUNT(SC), .LINE_COUNT(LC), .TAG_WIDTH(TW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .flush_valid_i(flush_valid), .flush_ready_o(flush_ready), .flush_busy_o(flush_busy),
    .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready),
    .lookup_addr_i(lookup_addr), .lookup_tag_i(lookup_tag),
    .lookup_rvalid_o(lookup_rvalid), .lookup_hit_o(lookup_hit), .lookup_err_o(lookup_err),
    .write_valid_i(write_valid), .write_ready_o(write_ready),
    .write_addr_i(write_addr), .write_set_i(write_set),
    .write_tag_i(write_tag), .write_err_i(write_err),
    .ram_enable_o(ram_enable), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
    .ram_wtag_o(ram_wtag), .ram_rtag_i(ram_rtag)
  );

  // Tag SRAM: one array per way, 1-cycle read latency.
  logic [EW-1:0] sram [SC][LC];
  always @(posedge clk) begin
    for (int i = 0; i < SC; i++) begin
      if (ram_enable[i]) begin
        if (ram_write) sram[i][ram_addr] <= ram_wtag[i*EW +: EW];
        else           ram_rtag[i*EW +: EW] <= sram[i][ram_addr];
      end
    end
  end

  typedef struct packed {
    logic          v;
    logic          e;
    logic [TW-1:0] t;
  } entry_t;

  typedef struct {
    logic [SC-1:0] hit;
    logic          err;
    int            cyc;
  } exp_t;

  entry_t model [SC][LC];
  exp_t   sb[$];
  int     total = 0, bad = 0, cyc = 0;
  int     sweep_left = 0;
  bit     rst_pend = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < SC; s++)
      for (int l = 0; l < LC; l++) model[s][l] = '0;
  endtask

  // One clock of stimulus plus prediction of everything the DUT shows that cycle.
  task automatic step(input logic rst, input logic fv,
                      input logic wv, input logic [AW-1:0] wa, input logic [SA-1:0] ws,
                      input logic [TW-1:0] wt, input logic we,
                      input logic lv, input logic [AW-1:0] la, input logic [TW-1:0] lt);
    logic [SC-1:0]    oh;
    logic [SC*EW-1:0] wexp;
    exp_t             e;
    @(posedge clk);
    #1;
    if (rst_pend) begin sb.delete(); rst_pend = 1'b0; end
    rst_ni = rst; flush_valid = fv;
    write_valid = wv; write_addr = wa; write_set = ws; write_tag = wt; write_err = we;
    lookup_valid = lv; lookup_addr = la; lookup_tag = lt;
    @(negedge clk);
    if (!rst) begin
      sweep_left = LC;
      clear_model();
      rst_pend = 1'b1;
    end else if (sweep_left > 0) begin
      check("sweep_busy", flush_busy, 1'b1);
      check("sweep_readies", {flush_ready, write_ready, lookup_ready}, 3'b000);
      check("sweep_port", {ram_enable, ram_write, ram_addr},
            {{SC{1'b1}}, 1'b1, AW'(LC - sweep_left)});
      check("sweep_wdata", ram_wtag, '0);
      sweep_left--;
    end else begin
      check("idle_busy", flush_busy, 1'b0);
      check("idle_readies", {flush_ready, write_ready, lookup_ready}, {1'b1, !fv, !fv && !wv});
      if (fv) begin
        check("flush_no_access", ram_enable, '0);
        sweep_left = LC;
        clear_model();
      end else if (wv) begin
        oh = '0;
        oh[ws] = 1'b1;
        wexp = {SC{we, 1'b1, wt}};
        check("write_port", {ram_enable, ram_write, ram_addr}, {oh, 1'b1, wa});
        check("write_data", ram_wtag, wexp);
        model[ws][wa] = '{v: 1'b1, e: we, t: wt};
      end else if (lv) begin
        check("read_port", {ram_enable, ram_write, ram_addr}, {{SC{1'b1}}, 1'b0, la});
        check("read_wdata", ram_wtag, '0);
        e.hit = '0;
        e.err = 1'b0;
        for (int s = 0; s < SC; s++) begin
          e.hit[s] = model[s][la].v && (model[s][la].t == lt);
          e.err    = e.err | (e.hit[s] & model[s][la].e);
        end
        e.cyc = cyc;
        sb.push_back(e);
      end else begin
        check("no_access", ram_enable, '0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [SA-1:0] s, input logic [TW-1:0] t, input logic e);
    step(1, 0, 1, a, s, t, e, 0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [TW-1:0] t);
    step(1, 0, 0, '0, '0, '0, 0, 1, a, t);
  endtask

  // Response monitor: pops one expectation per rvalid, demands zeros otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (lookup_rvalid) begin
      if (sb.size() == 0) begin
        check("rvalid_unexpected", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("rvalid_latency", cyc, e.cyc + 1);
        check("lookup_hit", lookup_hit, e.hit);
        check("lookup_err", lookup_err, e.err);
      end
    end else if (rst_ni) begin
      check("quiet_result", {lookup_hit, lookup_err}, '0);
    end
  end

  initial begin
    logic [TW-1:0] tags [4];
    clear_model();
    for (int i = 0; i < 4; i++) tags[i] = TW'($urandom);

    // Reset, full sweep, then readies rise.
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0, '0, '0, 0, 0, '0, '0);
    idle(LC + 4);

    wr(5, 2, 20'hABCDE, 0);
    rd(5, 20'hABCDE);
    rd(5, 20'hABCDF);

    // Write and lookup together: write wins, lookup retried next cycle.
    step(1, 0, 1, 7, 3, 20'h12345, 0, 1, 7, 20'h12345);
    rd(7, 20'h12345);

    wr(9, 0, 20'h55555, 1);
    rd(9, 20'h55555);

    wr(11, 1, 20'h0F0F0, 0);
    wr(11, 4, 20'h0F0F0, 0);
    rd(11, 20'h0F0F0);

    // Lookup pending while flush wins over write and lookup.
    rd(5, 20'hABCDE);
    step(1, 1, 1, 5, 1, 20'hABCDE, 0, 1, 5, 20'hABCDE);
    idle(LC);
    rd(5, 20'hABCDE);
    idle(2);

    // Reset in the middle of a sweep at line 60.
    step(1, 1, 0, '0, '0, '0, 0, 0, '0, '0);
    idle(60);
    step(0, 0, 0, '0, '0, '0, 0, 0, '0, '0);
    idle(LC + 2);

    for (int i = 0; i < 3000; i++) begin
      step(1, ($urandom_range(299) == 0),
           ($urandom_range(2) == 0), AW'($urandom_range(7)), SA'($urandom_range(SC - 1)),
           tags[$urandom_range(3)], 1'($urandom_range(1)),
           ($urandom_range(3) != 0), AW'($urandom_range(7)), tags[$urandom_range(3)]);
    end
    idle(3);

    check("responses_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
